// File: rtl/pattern_pkg.sv
// Shared constants for the HDMI test-pattern sequencer: colours, pattern
// indices and the sequencing FSM state type.
package pattern_pkg;

  localparam logic [23:0] WHITE   = 24'hFFFFFF;
  localparam logic [23:0] YELLOW  = 24'hFFFF00;
  localparam logic [23:0] CYAN    = 24'h00FFFF;
  localparam logic [23:0] GREEN   = 24'h00FF00;
  localparam logic [23:0] MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RED     = 24'hFF0000;
  localparam logic [23:0] BLUE    = 24'h0000FF;
  localparam logic [23:0] BLACK   = 24'h000000;

  localparam logic [2:0] PAT_BARS    = 3'd0;
  localparam logic [2:0] PAT_SOLID   = 3'd1;
  localparam logic [2:0] PAT_CHECKER = 3'd2;
  localparam logic [2:0] PAT_RAMP    = 3'd3;
  localparam logic [2:0] PAT_MOVE    = 3'd4;
  localparam logic [2:0] PAT_COUNT   = 3'd5;

  typedef enum logic {
    SHOW  = 1'b0,
    ARMED = 1'b1
  } seq_state_t;

  // Bars 0..6 in broadcast order; anything beyond the last bar stays blue.
  function automatic logic [23:0] bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    bar_colour = WHITE;
      3'd1:    bar_colour = YELLOW;
      3'd2:    bar_colour = CYAN;
      3'd3:    bar_colour = GREEN;
      3'd4:    bar_colour = MAGENTA;
      3'd5:    bar_colour = RED;
      default: bar_colour = BLUE;
    endcase
  endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Video-timing inputs, user controls and RGB/status outputs exchanged
// between hdmi_tx-side logic and the pattern sequencer.
interface pattern_sequencer_if #(
  parameter int H_WIDTH = 10,
  parameter int V_WIDTH = 10
);
  logic               inActiveDisplay;
  logic [H_WIDTH-1:0] hPosCounter;
  logic [V_WIDTH-1:0] vPosCounter;
  logic               autoAdvance;
  logic               nextPattern;
  logic [7:0]         redByte;
  logic [7:0]         greenByte;
  logic [7:0]         blueByte;
  logic [2:0]         patternIndex;
  logic               frameStart;

  modport master (
    output inActiveDisplay, hPosCounter, vPosCounter, autoAdvance, nextPattern,
    input  redByte, greenByte, blueByte, patternIndex, frameStart
  );

  modport slave (
    input  inActiveDisplay, hPosCounter, vPosCounter, autoAdvance, nextPattern,
    output redByte, greenByte, blueByte, patternIndex, frameStart
  );
endinterface

// File: rtl/pattern_sequencer_frame_edge_detect.sv
// Detects the vertical counter wrapping to 0: frame_tick is the same-cycle
// event, frameStart the registered one-cycle pulse that follows it.
module frame_edge_detect #(
  parameter int V_WIDTH = 10
) (
  input  logic               pixelClock,
  input  logic               resetN,
  input  logic [V_WIDTH-1:0] vPosCounter,
  output logic               frame_tick,
  output logic               frameStart
);
  logic [V_WIDTH-1:0] v_prev;

  assign frame_tick = (vPosCounter == '0) && (v_prev != '0);

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      v_prev     <= '0;
      frameStart <= 1'b0;
    end else begin
      v_prev     <= vPosCounter;
      frameStart <= frame_tick;
    end
  end
endmodule

// File: rtl/pattern_sequencer.sv
// Frame-synchronous test-pattern source for hdmi_tx: selects one of five
// patterns and only switches at frame boundaries so no frame is torn.
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int H_WIDTH            = 10,
  parameter int V_WIDTH            = 10,
  parameter int BAR_WIDTH          = 102,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int MOVE_STEP          = 4,
  parameter int MOVE_BAR_WIDTH     = 16,
  parameter int H_ACTIVE           = 720
) (
  input  logic                pixelClock,
  input  logic                resetN,
  pattern_sequencer_if.slave  bus
);
  localparam int HW1 = H_WIDTH + 1;
  localparam int CW  = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_PATTERN - 1);
  localparam logic [2:0]    PAT_LAST = 3'(PAT_COUNT - 3'd1);

  seq_state_t         state, state_next;
  logic [2:0]         pat, pat_next;
  logic [CW-1:0]      cnt, cnt_next, cnt_inc;
  logic [H_WIDTH-1:0] pos, pos_next, pos_adv;
  logic [HW1-1:0]     pos_sum;
  logic               frame_tick, frame_start;

  frame_edge_detect #(.V_WIDTH(V_WIDTH)) u_edge (
    .pixelClock  (pixelClock),
    .resetN      (resetN),
    .vPosCounter (bus.vPosCounter),
    .frame_tick  (frame_tick),
    .frameStart  (frame_start)
  );

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      state <= SHOW;
      pat   <= PAT_BARS;
      cnt   <= '0;
      pos   <= '0;
    end else begin
      state <= state_next;
      pat   <= pat_next;
      cnt   <= cnt_next;
      pos   <= pos_next;
    end
  end

  // Extra bit keeps pos+MOVE_STEP from overflowing before the wrap test.
  assign pos_sum = {1'b0, pos} + HW1'(MOVE_STEP);
  assign pos_adv = (pos_sum >= HW1'(H_ACTIVE)) ? '0 : pos_sum[H_WIDTH-1:0];
  assign cnt_inc = (cnt == CNT_LAST) ? cnt : cnt + 1'b1;

  always_comb begin
    state_next = state;
    pat_next   = pat;
    cnt_next   = cnt;
    pos_next   = pos;
    case (state)
      SHOW: begin
        if (frame_tick) begin
          cnt_next = cnt_inc;
          pos_next = pos_adv;
        end
        if (bus.nextPattern || (frame_tick && bus.autoAdvance && cnt_inc == CNT_LAST))
          state_next = ARMED;
      end
      ARMED: begin
        if (frame_tick) begin
          state_next = SHOW;
          pat_next   = (pat == PAT_LAST) ? PAT_BARS : pat + 3'd1;
          cnt_next   = '0;
          pos_next   = '0;
        end
      end
      default: state_next = SHOW;
    endcase
  end

  logic [H_WIDTH-1:0] bar_idx;
  logic [HW1-1:0]     h_ext, pos_ext;
  logic               in_move;
  logic [23:0]        pixel, rgb;

  assign bar_idx = bus.hPosCounter / H_WIDTH'(BAR_WIDTH);
  assign h_ext   = {1'b0, bus.hPosCounter};
  assign pos_ext = {1'b0, pos};
  assign in_move = (h_ext >= pos_ext) && (h_ext < pos_ext + HW1'(MOVE_BAR_WIDTH));

  always_comb begin
    pixel = BLACK;
    case (pat)
      PAT_BARS:    pixel = bar_colour((bar_idx > H_WIDTH'(6)) ? 3'd7 : bar_idx[2:0]);
      PAT_SOLID:   pixel = WHITE;
      PAT_CHECKER: pixel = (bus.hPosCounter[5] ^ bus.vPosCounter[5]) ? WHITE : BLACK;
      PAT_RAMP:    pixel = {3{bus.hPosCounter[9:2]}};
      PAT_MOVE:    pixel = in_move ? WHITE : BLACK;
      default:     pixel = BLACK;
    endcase
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) rgb <= BLACK;
    else         rgb <= bus.inActiveDisplay ? pixel : BLACK;
  end

  assign bus.redByte      = rgb[23:16];
  assign bus.greenByte    = rgb[15:8];
  assign bus.blueByte     = rgb[7:0];
  assign bus.patternIndex = pat;
  assign bus.frameStart   = frame_start;
endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed and randomized bench for pattern_sequencer, checked against a
// frame-level behavioural model.
module tb_pattern_sequencer;
  localparam int FPP = 3;
  localparam int HA  = 720;
  localparam int STEP = 4;
  localparam int MBW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pattern_sequencer_if #(.H_WIDTH(10), .V_WIDTH(10)) bus ();

  pattern_sequencer #(
    .H_WIDTH(10), .V_WIDTH(10), .BAR_WIDTH(102), .FRAMES_PER_PATTERN(FPP),
    .MOVE_STEP(STEP), .MOVE_BAR_WIDTH(MBW), .H_ACTIVE(HA)
  ) dut (
    .pixelClock (clk),
    .resetN     (rst_n),
    .bus        (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  int m_pat, m_cnt, m_pos, m_vprev, m_rgb;
  bit m_armed, m_fs;
  int bar_tbl [7] = '{32'hFFFFFF, 32'hFFFF00, 32'h00FFFF, 32'h00FF00,
                      32'hFF00FF, 32'hFF0000, 32'h0000FF};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pixel_ref(input int pat, input int h, input int v, input int pos);
    case (pat)
      0: return bar_tbl[(h / 102 > 6) ? 6 : h / 102];
      1: return 32'hFFFFFF;
      2: return (((h / 32) % 2) != ((v / 32) % 2)) ? 32'hFFFFFF : 0;
      3: return ((h / 4) % 256) * 32'h010101;
      4: return (h >= pos && h < pos + MBW) ? 32'hFFFFFF : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_pat = 0; m_cnt = 0; m_pos = 0; m_vprev = 0; m_rgb = 0;
    m_armed = 0; m_fs = 0;
  endtask

  // One clock: advance the model with the inputs the DUT sampled, then compare.
  task automatic step();
    int h, v;
    bit fs_now;
    h = int'(bus.hPosCounter);
    v = int'(bus.vPosCounter);
    @(posedge clk);
    fs_now  = (v == 0) && (m_vprev != 0);
    m_vprev = v;
    m_rgb   = bus.inActiveDisplay ? pixel_ref(m_pat, h, v, m_pos) : 0;
    m_fs    = fs_now;
    if (m_armed) begin
      if (fs_now) begin
        m_pat = (m_pat + 1) % 5; m_armed = 0; m_cnt = 0; m_pos = 0;
      end
    end else begin
      if (fs_now) begin
        if (m_cnt < FPP - 1) m_cnt++;
        m_pos = (m_pos + STEP >= HA) ? 0 : m_pos + STEP;
      end
      if (bus.nextPattern || (fs_now && bus.autoAdvance && m_cnt == FPP - 1)) m_armed = 1;
    end
    #1;
    check_eq("rgb", {8'h00, bus.redByte, bus.greenByte, bus.blueByte}, m_rgb);
    check_eq("pat", {29'd0, bus.patternIndex}, m_pat);
    check_eq("fs", {31'd0, bus.frameStart}, {31'd0, m_fs});
  endtask

  task automatic frame(input bit next_on_start);
    bus.vPosCounter = 10'd1;
    step();
    bus.vPosCounter = 10'd0;
    bus.nextPattern = next_on_start;
    step();
    bus.nextPattern = 1'b0;
  endtask

  task automatic pulse_next();
    bus.nextPattern = 1'b1;
    step();
    bus.nextPattern = 1'b0;
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_rgb", {8'h00, bus.redByte, bus.greenByte, bus.blueByte}, 0);
    check_eq("rst_pat", {29'd0, bus.patternIndex}, 0);
    check_eq("rst_fs", {31'd0, bus.frameStart}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pix(input string tag, input int h, input int v, input int exp);
    bus.hPosCounter = 10'(h);
    bus.vPosCounter = 10'(v);
    step();
    check_eq(tag, {8'h00, bus.redByte, bus.greenByte, bus.blueByte}, exp);
  endtask

  int sweep_h [7] = '{0, 101, 102, 407, 408, 713, 714};
  int sweep_c [7] = '{32'hFFFFFF, 32'hFFFFFF, 32'hFFFF00, 32'h00FF00,
                      32'hFF00FF, 32'h0000FF, 32'h0000FF};

  initial begin
    bus.inActiveDisplay = 1'b1;
    bus.hPosCounter = 10'd50;
    bus.vPosCounter = 10'd5;
    bus.autoAdvance = 1'b0;
    bus.nextPattern = 1'b0;
    model_reset();

    // Reset release with an active pixel in bar 0
    do_reset();
    step();
    check_eq("rel_rgb", {8'h00, bus.redByte, bus.greenByte, bus.blueByte}, 32'hFFFFFF);

    // Colour-bar sweep and blanking
    for (int i = 0; i < 7; i++) pix("bars", sweep_h[i], 5, sweep_c[i]);
    bus.inActiveDisplay = 1'b0;
    pix("blank", 102, 5, 0);
    bus.inActiveDisplay = 1'b1;

    // Manual request waits for the frame start; a second request is ignored
    bus.vPosCounter = 10'd200;
    pulse_next();
    step();
    check_eq("armed_pat", {29'd0, bus.patternIndex}, 0);
    pulse_next();
    bus.vPosCounter = 10'd0;
    step();
    check_eq("adv_pat", {29'd0, bus.patternIndex}, 1);
    check_eq("adv_fs", {31'd0, bus.frameStart}, 1);
    bus.vPosCounter = 10'd1;
    step();
    check_eq("once_pat", {29'd0, bus.patternIndex}, 1);

    // Asynchronous reset mid-line
    do_reset();

    // Timed advance every FPP frames; a coincident request adds nothing
    bus.autoAdvance = 1'b1;
    for (int p = 1; p <= 5; p++) begin
      frame(1'b0);
      frame(1'b0);
      check_eq("auto_hold", {29'd0, bus.patternIndex}, 32'((p - 1) % 5));
      frame(p == 2);
      check_eq("auto_pat", {29'd0, bus.patternIndex}, 32'(p % 5));
    end
    bus.autoAdvance = 1'b0;

    // Moving bar position and wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse_next();
      frame(1'b0);
    end
    check_eq("move_pat", {29'd0, bus.patternIndex}, 4);
    for (int i = 0; i < 10; i++) frame(1'b0);
    pix("mv39", 39, 5, 0);
    pix("mv40", 40, 5, 32'hFFFFFF);
    pix("mv55", 55, 5, 32'hFFFFFF);
    pix("mv56", 56, 5, 0);
    for (int i = 0; i < 169; i++) frame(1'b0);
    pix("mv716", 716, 5, 32'hFFFFFF);
    pix("mv715", 715, 5, 0);
    frame(1'b0);
    pix("wrap0", 0, 5, 32'hFFFFFF);
    pix("wrap716", 716, 5, 0);

    // Checkerboard and ramp
    do_reset();
    for (int i = 0; i < 2; i++) begin
      pulse_next();
      frame(1'b0);
    end
    pix("chk_w", 32, 0, 32'hFFFFFF);
    pix("chk_b", 32, 32, 0);
    pulse_next();
    frame(1'b0);
    pix("ramp", 700, 5, 32'hAFAFAF);

    // Randomized run against the model
    do_reset();
    bus.autoAdvance = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bus.inActiveDisplay = ($urandom % 4) != 0;
      bus.hPosCounter = 10'($urandom_range(0, 1023));
      bus.vPosCounter = (($urandom % 6) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      bus.nextPattern = ($urandom % 20) == 0;
      if (($urandom % 200) == 0) bus.autoAdvance = ~bus.autoAdvance;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
